// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite channel types and response codes.
package axi4l_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [2:0]  prot_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t awaddr;
  prot_t awprot;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  prot_t arprot;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/ibex_axi4l_bridge.sv
// Ibex req/gnt/rvalid port to AXI4-Lite master, one transaction in flight.
// Read >= 2 cycles gnt->rvalid, write >= 3; gnt held low until the bus side is idle again.
module ibex_axi4l_bridge
  import axi4l_pkg::*;
#(
  parameter int unsigned INSTR_PORT = 0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req,
  output logic        gnt,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  axi4l_if.master     m
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;

  localparam prot_t Prot = {INSTR_PORT[0], 2'b00};

  state_e state_q;
  addr_t  addr_q;
  data_t  wdata_q;
  strb_t  strb_q;
  logic   arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic   aw_done_q, w_done_q, aw_done_d, w_done_d;
  logic   rvalid_q, err_q;
  data_t  rdata_q;

  assign gnt = req & (state_q == IDLE) & ~areset;

  always_comb begin
    aw_done_d = aw_done_q | (awvalid_q & m.awready);
    w_done_d  = w_done_q  | (wvalid_q  & m.wready);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt) begin
            addr_q  <= {addr[31:2], 2'b00};
            wdata_q <= wdata;
            strb_q  <= be;
            if (we) begin
              state_q   <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (m.arready) begin
            arvalid_q <= 1'b0;
            // rready is already high here, so R may land with AR
            if (m.rvalid) begin
              state_q  <= IDLE;
              rready_q <= 1'b0;
              rdata_q  <= m.rdata;
              err_q    <= m.rresp[1];
              rvalid_q <= 1'b1;
            end else begin
              state_q <= RD_DATA;
            end
          end
        end
        RD_DATA: begin
          if (m.rvalid) begin
            state_q  <= IDLE;
            rready_q <= 1'b0;
            rdata_q  <= m.rdata;
            err_q    <= m.rresp[1];
            rvalid_q <= 1'b1;
          end
        end
        WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          awvalid_q <= ~aw_done_d;
          wvalid_q  <= ~w_done_d;
          if (aw_done_d && w_done_d) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m.bvalid) begin
            state_q  <= IDLE;
            bready_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= m.bresp[1];
            rvalid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

  assign m.araddr  = addr_q;
  assign m.arprot  = Prot;
  assign m.arvalid = arvalid_q;
  assign m.rready  = rready_q;
  assign m.awaddr  = addr_q;
  assign m.awprot  = Prot;
  assign m.awvalid = awvalid_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = strb_q;
  assign m.wvalid  = wvalid_q;
  assign m.bready  = bready_q;

  // Low response bit only separates OKAY/EXOKAY and SLVERR/DECERR.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], m.rresp[0], m.bresp[0], m.aclk, m.aresetn};

endmodule

// File: tb/tb_ibex_axi4l_bridge.sv
module tb_ibex_axi4l_bridge;
  import axi4l_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        c_req, c_gnt, c_we, c_rvalid, c_err;
  logic [3:0]  c_be;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        p2_req, p2_gnt, p2_we, p2_rvalid, p2_err;
  logic [3:0]  p2_be;
  logic [31:0] p2_addr, p2_wdata, p2_rdata;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 aclk = ~aclk;

  axi4l_if axi  (.aclk(aclk), .aresetn(~areset));
  axi4l_if axi2 (.aclk(aclk), .aresetn(~areset));

  ibex_axi4l_bridge #(.INSTR_PORT(0)) dut (
    .aclk(aclk), .areset(areset), .req(c_req), .gnt(c_gnt), .we(c_we), .be(c_be),
    .addr(c_addr), .wdata(c_wdata), .rvalid(c_rvalid), .rdata(c_rdata), .err(c_err), .m(axi)
  );

  ibex_axi4l_bridge #(.INSTR_PORT(1)) dut_i (
    .aclk(aclk), .areset(areset), .req(p2_req), .gnt(p2_gnt), .we(p2_we), .be(p2_be),
    .addr(p2_addr), .wdata(p2_wdata), .rvalid(p2_rvalid), .rdata(p2_rdata), .err(p2_err), .m(axi2)
  );

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic slave_idle();
    axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
  endtask

  task automatic test_reset();
    areset = 1; c_req = 1; c_we = 0; c_be = 4'hF; c_addr = 32'h1111_1113; c_wdata = 32'hFFFF_FFFF;
    repeat (2) cyc();
    #1;
    n_cmp++; if (c_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", c_gnt); end
    n_cmp++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshakes: got %b want 00000",
                         {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); end
    n_cmp++; if ({c_rvalid, c_err, c_rdata} !== 34'b0) begin
      n_fail++; $display("FAIL reset_core_rsp: got rvalid %b err %b rdata %h want 0", c_rvalid, c_err, c_rdata); end
    n_cmp++; if ({axi.araddr, axi.wdata, axi.wstrb} !== 68'b0) begin
      n_fail++; $display("FAIL reset_payload: got addr %h wdata %h strb %h want 0", axi.araddr, axi.wdata, axi.wstrb); end
    cyc();
    areset = 0; c_req = 0;
  endtask

  task automatic test_read_zero_wait();
    cyc();
    c_req = 1; c_we = 0; c_addr = 32'h1000_0006;
    #1;
    n_cmp++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", c_gnt); end
    cyc();
    c_req = 0; axi.arready = 1; axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF; axi.rresp = RESP_OKAY;
    #1;
    n_cmp++; if ({axi.arvalid, axi.rready, c_rvalid} !== 3'b110) begin
      n_fail++; $display("FAIL rd_c1_flags: got arvalid/rready/rvalid %b want 110", {axi.arvalid, axi.rready, c_rvalid}); end
    n_cmp++; if (axi.araddr !== 32'h1000_0004) begin n_fail++; $display("FAIL rd_araddr: got %h want 10000004", axi.araddr); end
    n_cmp++; if (axi.arprot !== 3'b000) begin n_fail++; $display("FAIL rd_arprot: got %b want 000", axi.arprot); end
    cyc();
    slave_idle();
    #1;
    n_cmp++; if ({c_rvalid, c_err, c_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL rd_rsp: got rvalid %b err %b rdata %h want 1 0 deadbeef", c_rvalid, c_err, c_rdata); end
    n_cmp++; if ({axi.arvalid, axi.rready} !== 2'b00) begin
      n_fail++; $display("FAIL rd_c2_idle: got arvalid/rready %b want 00", {axi.arvalid, axi.rready}); end
    cyc();
    #1;
    n_cmp++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_len: got rvalid %b want 0", c_rvalid); end
  endtask

  task automatic test_write_w_first();
    cyc();
    c_req = 1; c_we = 1; c_be = 4'b0011; c_wdata = 32'h1234_5678; c_addr = 32'h2000_0009;
    #1;
    n_cmp++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", c_gnt); end
    cyc();
    c_req = 0; axi.wready = 1;
    #1;
    n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b110) begin
      n_fail++; $display("FAIL wr_c1_flags: got aw/w/b %b want 110", {axi.awvalid, axi.wvalid, axi.bready}); end
    n_cmp++; if ({axi.awaddr, axi.wdata, axi.wstrb} !== {32'h2000_0008, 32'h1234_5678, 4'h3}) begin
      n_fail++; $display("FAIL wr_payload: got %h %h %h want 20000008 12345678 3", axi.awaddr, axi.wdata, axi.wstrb); end
    cyc();
    axi.wready = 0;
    #1;
    n_cmp++; if ({axi.awvalid, axi.wvalid} !== 2'b10) begin
      n_fail++; $display("FAIL wr_c2_wdrop: got aw/w %b want 10", {axi.awvalid, axi.wvalid}); end
    cyc();
    axi.awready = 1;
    #1;
    n_cmp++; if ({axi.awvalid, axi.bready} !== 2'b10) begin
      n_fail++; $display("FAIL wr_c3_aw: got aw/b %b want 10", {axi.awvalid, axi.bready}); end
    cyc();
    axi.awready = 0;
    #1;
    n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin
      n_fail++; $display("FAIL wr_c4_resp: got aw/w/b %b want 001", {axi.awvalid, axi.wvalid, axi.bready}); end
    cyc();
    axi.bvalid = 1; axi.bresp = RESP_OKAY;
    #1;
    n_cmp++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_c5_early: got rvalid %b want 0", c_rvalid); end
    cyc();
    axi.bvalid = 0;
    #1;
    n_cmp++; if ({c_rvalid, c_err, c_rdata, axi.bready} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL wr_rsp: got rvalid %b err %b rdata %h bready %b want 1 0 0 0", c_rvalid, c_err, c_rdata, axi.bready); end
  endtask

  task automatic test_errors();
    logic  we_t [3] = '{1'b0, 1'b1, 1'b0};
    resp_t rs_t [3] = '{RESP_DECERR, RESP_SLVERR, RESP_EXOKAY};
    logic  ee_t [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      cyc();
      c_req = 1; c_we = we_t[k]; c_be = 4'hF; c_addr = 32'h5000_0000 + 32'(k * 16); c_wdata = 32'h7777_0000;
      #1;
      n_cmp++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL err%0d_gnt: got %b want 1", k, c_gnt); end
      cyc();
      c_req = 0;
      if (!we_t[k]) begin
        axi.arready = 1; axi.rvalid = 1; axi.rdata = 32'h1357_9BDF; axi.rresp = rs_t[k];
      end else begin
        axi.awready = 1; axi.wready = 1;
      end
      cyc();
      slave_idle();
      if (we_t[k]) begin
        axi.bvalid = 1; axi.bresp = rs_t[k];
        cyc();
        axi.bvalid = 0;
      end
      #1;
      n_cmp++; if ({c_rvalid, c_err, c_rdata} !== {1'b1, ee_t[k], (we_t[k] ? 32'h0 : 32'h1357_9BDF)}) begin
        n_fail++; $display("FAIL err%0d_rsp: got rvalid %b err %b rdata %h want 1 %b", k, c_rvalid, c_err, c_rdata, ee_t[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int          granted = 0, rsp_cnt = 0, ar_hs = 0, stall = 0, gnt_bad = 0, ar_bad = 0;
    logic        busy = 1'b0, r_pend = 1'b0;
    logic [31:0] r_dat = '0, exp;
    cyc();
    c_req = 1; c_we = 0; c_addr = 32'h3000_0000;
    for (int n = 0; n < 80 && rsp_cnt < 3; n++) begin
      axi.arready = 0; axi.rvalid = 0;
      if (r_pend) begin
        axi.rvalid = 1; axi.rdata = r_dat; axi.rresp = RESP_OKAY;
      end else if (axi.arvalid) begin
        stall++;
        if (stall > 2) axi.arready = 1;
      end
      #1;
      if (c_gnt !== (c_req & ~busy)) gnt_bad++;
      if (axi.arvalid && (ar_hs != rsp_cnt)) ar_bad++;
      if (c_rvalid) begin
        exp = (32'h3000_0000 + 32'(rsp_cnt * 4)) ^ 32'h5A5A_0000;
        n_cmp++; if (c_rdata !== exp) begin
          n_fail++; $display("FAIL b2b_rdata%0d: got %h want %h", rsp_cnt, c_rdata, exp); end
        rsp_cnt++;
      end
      if (axi.arvalid && axi.arready) begin
        ar_hs++; r_pend = 1; r_dat = axi.araddr ^ 32'h5A5A_0000; stall = 0;
      end else if (axi.rvalid && axi.rready) begin
        r_pend = 0; busy = 0;
      end
      if (c_gnt) begin busy = 1; granted++; end
      cyc();
      if (granted == 3) c_req = 0;
      c_addr = 32'h3000_0000 + 32'(granted * 4);
    end
    slave_idle();
    n_cmp++; if (rsp_cnt != 3) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 3", rsp_cnt); end
    n_cmp++; if (gnt_bad != 0) begin n_fail++; $display("FAIL b2b_gnt: got %0d bad cycles want 0", gnt_bad); end
    n_cmp++; if (ar_bad != 0) begin n_fail++; $display("FAIL b2b_overlap: got %0d early arvalid want 0", ar_bad); end
  endtask

  task automatic test_reset_mid_write();
    int pulses = 0;
    cyc();
    c_req = 1; c_we = 1; c_be = 4'hF; c_addr = 32'h4000_0000; c_wdata = 32'hAAAA_5555;
    cyc();
    c_req = 0; axi.awready = 1; axi.wready = 1;
    cyc();
    slave_idle();
    #1;
    n_cmp++; if (axi.bready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_bready: got %b want 1", axi.bready); end
    areset = 1;
    cyc();
    areset = 0;
    #1;
    n_cmp++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, c_rvalid} !== 6'b0) begin
      n_fail++; $display("FAIL rst_wr_flags: got %b want 000000",
                         {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, c_rvalid}); end
    for (int n = 0; n < 3; n++) begin
      cyc();
      #1;
      if (c_rvalid) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL rst_wr_no_rsp: got %0d pulses want 0", pulses); end
    cyc();
    c_req = 1; c_we = 0; c_addr = 32'h4000_0012;
    #1;
    n_cmp++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_rd_gnt: got %b want 1", c_gnt); end
    cyc();
    c_req = 0; axi.arready = 1; axi.rvalid = 1; axi.rdata = 32'h0BAD_F00D; axi.rresp = RESP_OKAY;
    #1;
    n_cmp++; if (axi.araddr !== 32'h4000_0010) begin n_fail++; $display("FAIL rst_rd_araddr: got %h want 40000010", axi.araddr); end
    cyc();
    slave_idle();
    #1;
    n_cmp++; if ({c_rvalid, c_err, c_rdata} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL rst_rd_rsp: got rvalid %b err %b rdata %h want 1 0 0badf00d", c_rvalid, c_err, c_rdata); end
  endtask

  task automatic test_instr_port();
    cyc();
    p2_req = 1; p2_addr = 32'h0000_0102;
    #1;
    n_cmp++; if (p2_gnt !== 1'b1) begin n_fail++; $display("FAIL ip_gnt: got %b want 1", p2_gnt); end
    cyc();
    p2_req = 0; axi2.arready = 1; axi2.rvalid = 1; axi2.rdata = 32'h0000_0013; axi2.rresp = RESP_OKAY;
    #1;
    n_cmp++; if ({axi2.arvalid, axi2.arprot, axi2.araddr} !== {1'b1, 3'b100, 32'h0000_0100}) begin
      n_fail++; $display("FAIL ip_arprot: got arvalid %b prot %b addr %h want 1 100 00000100", axi2.arvalid, axi2.arprot, axi2.araddr); end
    cyc();
    axi2.arready = 0; axi2.rvalid = 0;
    #1;
    n_cmp++; if ({p2_rvalid, p2_err, p2_rdata} !== {1'b1, 1'b0, 32'h0000_0013}) begin
      n_fail++; $display("FAIL ip_rsp: got rvalid %b err %b rdata %h want 1 0 00000013", p2_rvalid, p2_err, p2_rdata); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    c_req = 0; c_we = 0; c_be = 0; c_addr = 0; c_wdata = 0;
    p2_req = 0; p2_we = 0; p2_be = 4'hF; p2_addr = 0; p2_wdata = 0;
    slave_idle();
    axi.rdata = 0; axi.rresp = RESP_OKAY; axi.bresp = RESP_OKAY;
    axi2.arready = 0; axi2.rvalid = 0; axi2.awready = 0; axi2.wready = 0; axi2.bvalid = 0;
    axi2.rdata = 0; axi2.rresp = RESP_OKAY; axi2.bresp = RESP_OKAY;
    test_reset();
    test_read_zero_wait();
    test_write_w_first();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    test_instr_port();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
